// File: rtl/render_frame_sequencer_if.sv
// Bundles the transform-side, raster-side and frame-control signals of the sequencer.
// slave: the sequencer's view. master: the view of the surrounding pipeline and testbench.
// Optional RENDER_FRAME_STATS_EN adds the frame statistics outputs.
interface render_frame_sequencer_if #(
  parameter int DATAWIDTH  = 12,
  parameter int MAX_MODELS = 16
);
  localparam int NW = $clog2(MAX_MODELS + 1);
  localparam int VW = 3 * DATAWIDTH;

  logic          i_start;
  logic [NW-1:0] i_num_models;
  logic          o_ready;
  logic          o_finished;
  logic          o_tp_start;
  logic          i_tp_ready;
  logic          o_tp_next;
  logic [VW-1:0] i_v0;
  logic [VW-1:0] i_v1;
  logic [VW-1:0] i_v2;
  logic          i_tri_dv;
  logic          i_tri_last;
  logic [VW-1:0] o_v0;
  logic [VW-1:0] o_v1;
  logic [VW-1:0] o_v2;
  logic          o_tri_dv;
  logic          o_tri_last;
  logic          i_rast_ready;
  logic          i_rast_finished;
  logic          o_overflow;
`ifdef RENDER_FRAME_STATS_EN
  logic [31:0]   o_tri_count;
  logic [31:0]   o_stall_cycles;
`endif

  modport slave (
    input  i_start, i_num_models, i_tp_ready, i_v0, i_v1, i_v2, i_tri_dv, i_tri_last,
           i_rast_ready, i_rast_finished,
`ifdef RENDER_FRAME_STATS_EN
    output o_tri_count, o_stall_cycles,
`endif
    output o_ready, o_finished, o_tp_start, o_tp_next, o_v0, o_v1, o_v2, o_tri_dv,
           o_tri_last, o_overflow
  );

  modport master (
    output i_start, i_num_models, i_tp_ready, i_v0, i_v1, i_v2, i_tri_dv, i_tri_last,
           i_rast_ready, i_rast_finished,
`ifdef RENDER_FRAME_STATS_EN
    input  o_tri_count, o_stall_cycles,
`endif
    input  o_ready, o_finished, o_tp_start, o_tp_next, o_v0, o_v1, o_v2, o_tri_dv,
           o_tri_last, o_overflow
  );
endinterface

// File: rtl/render_frame_sequencer.sv
// Frame sequencer: launches the transform pipeline per model, buffers triangles, feeds the rasterizer.
// Latency: push into an empty FIFO reaches o_tri_dv two cycles later; o_tp_start/o_tp_next are combinational.
// Backpressure: o_tp_next drops one entry before full; i_rast_ready gates pops. Option: RENDER_FRAME_STATS_EN.
module render_frame_sequencer #(
  parameter int DATAWIDTH      = 12,
  parameter int MAX_MODELS     = 16,
  parameter int TRI_FIFO_DEPTH = 8
) (
  input logic                     clk,
  input logic                     rstn,
  render_frame_sequencer_if.slave bus
);
  localparam int NW = $clog2(MAX_MODELS + 1);
  localparam int VW = 3 * DATAWIDTH;
  localparam int AW = $clog2(TRI_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TRI_FIFO_DEPTH);
  localparam logic [AW:0] NEXT_LIM = (AW+1)'(TRI_FIFO_DEPTH - 1);

  typedef struct packed {
    logic [VW-1:0] v0;
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;
    logic          last;
  } tri_t;

  typedef enum logic [2:0] {IDLE, LAUNCH, STREAM, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [NW-1:0] n_models, model_cnt;
  tri_t          mem [TRI_FIFO_DEPTH];
  tri_t          rd_ent;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, last_model, frame_last;
  logic          push_req, push, pop, start_acc, tp_start, tp_next;
  logic          finished, overflow;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign last_model = (model_cnt == n_models - 1'b1);
  assign frame_last = bus.i_tri_last & last_model;
  assign pop        = ~empty & bus.i_rast_ready;
  assign push_req   = (state == STREAM) & bus.i_tri_dv;
  // A full FIFO still accepts when the same cycle frees an entry.
  assign push       = push_req & (~full | pop);
  assign rd_ent     = mem[rd_ptr];

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the combinational transform-side strobes.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    tp_start  = 1'b0;
    tp_next   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.i_start) begin
          start_acc = 1'b1;
          state_nxt = (bus.i_num_models == '0) ? DONE : LAUNCH;
        end
      end
      LAUNCH: begin
        if (bus.i_tp_ready) begin
          tp_start  = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        tp_next = (count < NEXT_LIM);
        if (push && bus.i_tri_last) state_nxt = last_model ? DRAIN : LAUNCH;
      end
      DRAIN: begin
        if (empty && bus.i_rast_finished) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Model bookkeeping and the sticky completion / overflow flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_models  <= '0;
      model_cnt <= '0;
      finished  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (start_acc) begin
        n_models  <= bus.i_num_models;
        model_cnt <= '0;
        finished  <= 1'b0;
      end else begin
        if (push && bus.i_tri_last) model_cnt <= model_cnt + 1'b1;
        // Covers both DRAIN->DONE and the cycle after a zero-model start.
        if (state_nxt == DONE) finished <= 1'b1;
      end
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // Triangle storage; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.i_v0, bus.i_v1, bus.i_v2, frame_last};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered raster-side outputs; vertices hold, last is qualified by valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.o_v0       <= '0;
      bus.o_v1       <= '0;
      bus.o_v2       <= '0;
      bus.o_tri_dv   <= 1'b0;
      bus.o_tri_last <= 1'b0;
    end else begin
      bus.o_tri_dv   <= pop;
      bus.o_tri_last <= pop & rd_ent.last;
      if (pop) begin
        bus.o_v0 <= rd_ent.v0;
        bus.o_v1 <= rd_ent.v1;
        bus.o_v2 <= rd_ent.v2;
      end
    end
  end

`ifdef RENDER_FRAME_STATS_EN
  logic [31:0] tri_count, stall_cycles;

  // Per-frame statistics, saturating.
  always_ff @(posedge clk) begin
    if (!rstn || start_acc) begin
      tri_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (push && tri_count != '1) tri_count <= tri_count + 1'b1;
      if (state == STREAM && !tp_next && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign bus.o_tri_count    = tri_count;
  assign bus.o_stall_cycles = stall_cycles;
`endif

  assign bus.o_ready    = (state == IDLE) | (state == DONE);
  assign bus.o_finished = finished;
  assign bus.o_overflow = overflow;
  // Gated by reset so an abort cannot leak one more launch or credit.
  assign bus.o_tp_start = tp_start & rstn;
  assign bus.o_tp_next  = tp_next & rstn;
endmodule

// File: tb/tb_render_frame_sequencer.sv
// Bench for render_frame_sequencer: directed frame scenarios with random data and handshakes.
// A frame-level model (phase, queue of stored triangles) predicts every output each cycle.
// Built with or without RENDER_FRAME_STATS_EN.
module tb_render_frame_sequencer;
  localparam int DW = 12, MM = 16, DEPTH = 8;
  localparam int NW = $clog2(MM + 1);
  localparam int VW = 3 * DW;
  localparam int EW = 3 * VW + 1;
  localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_STREAM = 2, PH_DRAIN = 3, PH_DONE = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  render_frame_sequencer_if #(.DATAWIDTH(DW), .MAX_MODELS(MM)) bus ();
  render_frame_sequencer #(.DATAWIDTH(DW), .MAX_MODELS(MM), .TRI_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int n_cmp = 0, n_err = 0;
  int ph, m_n, m_cnt, sent_in_model;
  int seen_tps, seen_dv, seen_last;
  logic m_fin, m_ovf, m_pend, m_dv, m_last;
  logic [VW-1:0] m_v0, m_v1, m_v2;
  logic [EW-1:0] q[$];
  logic [31:0] m_tri_cnt, m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE; m_n = 0; m_cnt = 0;
    m_fin = 0; m_ovf = 0; m_pend = 0; m_dv = 0; m_last = 0;
    m_v0 = '0; m_v1 = '0; m_v2 = '0;
    m_tri_cnt = '0; m_stall = '0;
    q.delete();
  endtask

  task automatic idle_in();
    bus.i_start = 0; bus.i_num_models = '0; bus.i_tp_ready = 0;
    bus.i_tri_dv = 0; bus.i_tri_last = 0; bus.i_rast_ready = 0; bus.i_rast_finished = 0;
    bus.i_v0 = '0; bus.i_v1 = '0; bus.i_v2 = '0;
  endtask

  task automatic rand_vtx();
    bus.i_v0 = VW'({$urandom, $urandom});
    bus.i_v1 = VW'({$urandom, $urandom});
    bus.i_v2 = VW'({$urandom, $urandom});
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registered outputs.
  task automatic step();
    logic e_ready, e_tps, e_tpn, acc, pop, push_req, push, was_empty;
    logic [EW-1:0] ent;
    #1;
    e_ready = (ph == PH_IDLE) || (ph == PH_DONE);
    e_tps = rstn && (ph == PH_LAUNCH) && bus.i_tp_ready;
    e_tpn = rstn && (ph == PH_STREAM) && (q.size() < DEPTH - 1);
    chk("o_ready", 128'(bus.o_ready), 128'(e_ready));
    chk("o_tp_start", 128'(bus.o_tp_start), 128'(e_tps));
    chk("o_tp_next", 128'(bus.o_tp_next), 128'(e_tpn));
    if (bus.o_tp_start) seen_tps++;
    acc = e_ready && bus.i_start;
    pop = (q.size() > 0) && bus.i_rast_ready;
    push_req = (ph == PH_STREAM) && bus.i_tri_dv;
    push = push_req && ((q.size() < DEPTH) || pop);
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      if (acc) begin
        m_tri_cnt = '0; m_stall = '0;
      end else begin
        if (push && m_tri_cnt != 32'hFFFF_FFFF) m_tri_cnt++;
        if (ph == PH_STREAM && !e_tpn && m_stall != 32'hFFFF_FFFF) m_stall++;
      end
      m_dv = pop; m_last = 0;
      if (pop) begin
        ent = q.pop_front();
        {m_v0, m_v1, m_v2, m_last} = ent;
      end
      if (push) q.push_back({bus.i_v0, bus.i_v1, bus.i_v2, bus.i_tri_last && (m_cnt == m_n - 1)});
      if (push_req && !push) m_ovf = 1;
      if (acc) begin
        m_fin = 0; m_n = int'(bus.i_num_models); m_cnt = 0;
        if (m_n == 0) begin ph = PH_DONE; m_pend = 1; end
        else ph = PH_LAUNCH;
      end else begin
        case (ph)
          PH_LAUNCH: if (bus.i_tp_ready) ph = PH_STREAM;
          PH_STREAM: if (push && bus.i_tri_last) begin
            m_cnt++;
            ph = (m_cnt == m_n) ? PH_DRAIN : PH_LAUNCH;
          end
          PH_DRAIN: if (was_empty && bus.i_rast_finished) begin m_fin = 1; ph = PH_DONE; end
          PH_DONE: if (m_pend) begin m_fin = 1; m_pend = 0; end
          default: ;
        endcase
      end
    end
    #1;
    chk("o_tri_dv", 128'(bus.o_tri_dv), 128'(m_dv));
    chk("o_tri_last", 128'(bus.o_tri_last), 128'(m_last));
    chk("o_v0", 128'(bus.o_v0), 128'(m_v0));
    chk("o_v1", 128'(bus.o_v1), 128'(m_v1));
    chk("o_v2", 128'(bus.o_v2), 128'(m_v2));
    chk("o_finished", 128'(bus.o_finished), 128'(m_fin));
    chk("o_overflow", 128'(bus.o_overflow), 128'(m_ovf));
    chk("fifo_count", 128'(dut.count), 128'(q.size()));
`ifdef RENDER_FRAME_STATS_EN
    chk("o_tri_count", 128'(bus.o_tri_count), 128'(m_tri_cnt));
    chk("o_stall_cycles", 128'(bus.o_stall_cycles), 128'(m_stall));
`endif
    if (bus.o_tri_dv) seen_dv++;
    if (bus.o_tri_dv && bus.o_tri_last) seen_last++;
    @(negedge clk);
  endtask

  // Random handshakes until the frame completes; triangles offered only while credit is up.
  task automatic stream_loop(input int k, input int budget);
    int cyc = 0;
    while (!(ph == PH_DONE && m_fin) && cyc < budget) begin
      bus.i_tp_ready = 1'($urandom_range(0, 1));
      bus.i_rast_ready = ($urandom_range(0, 3) != 0);
      bus.i_rast_finished = (ph == PH_DRAIN) && ($urandom_range(0, 1) == 1);
      rand_vtx();
      if (ph == PH_STREAM && q.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) begin
        bus.i_tri_dv = 1;
        bus.i_tri_last = (sent_in_model == k - 1);
      end else begin
        bus.i_tri_dv = 0;
        bus.i_tri_last = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
      if (bus.i_tri_dv) sent_in_model = bus.i_tri_last ? 0 : sent_in_model + 1;
    end
    idle_in();
    chk("frame_timeout", 128'(cyc < budget), 128'(1));
  endtask

  task automatic run_frame(input int n, input int k);
    seen_tps = 0; seen_dv = 0; seen_last = 0; sent_in_model = 0;
    bus.i_start = 1; bus.i_num_models = NW'(n);
    step();
    bus.i_start = 0;
    stream_loop(k, 2000);
    chk("tp_start_pulses", 128'(seen_tps), 128'(n));
    chk("dv_pulses", 128'(seen_dv), 128'(n * k));
    chk("last_pulses", 128'(seen_last), 128'(n > 0));
  endtask

  initial begin
    idle_in();
    rstn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rstn = 1;
    #1;
    chk("rst_ready", 128'(bus.o_ready), 128'(1));
    chk("rst_finished", 128'(bus.o_finished), 128'(0));
    chk("rst_tri_dv", 128'(bus.o_tri_dv), 128'(0));
    chk("rst_v0", 128'(bus.o_v0), 128'(0));
    chk("rst_overflow", 128'(bus.o_overflow), 128'(0));
    @(negedge clk);

    // Single model, three triangles; then three models of two triangles.
    run_frame(1, 3);
    chk("n1_finished", 128'(bus.o_finished), 128'(1));
    run_frame(3, 2);
    chk("n3_finished", 128'(bus.o_finished), 128'(1));

    // Zero-model frame completes on its own without any launch.
    seen_tps = 0;
    bus.i_start = 1; bus.i_num_models = '0;
    step();
    bus.i_start = 0;
    step();
    chk("n0_finished", 128'(bus.o_finished), 128'(1));
    chk("n0_no_launch", 128'(seen_tps), 128'(0));

    // Fill to full, push and pop at full, then overflow one triangle.
    bus.i_start = 1; bus.i_num_models = NW'(1);
    step();
    bus.i_start = 0; bus.i_tp_ready = 1;
    step();
    bus.i_tp_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_tri_dv = 1; bus.i_tri_last = 0; rand_vtx();
      if (i == DEPTH - 1) chk("tp_next_low_at7", 128'(bus.o_tp_next), 128'(0));
      if (i == DEPTH - 2) chk("tp_next_high_at6", 128'(bus.o_tp_next), 128'(1));
      step();
    end
    chk("full_count", 128'(dut.count), 128'(DEPTH));
    for (int i = 0; i < 10; i++) begin
      bus.i_tri_dv = 1; bus.i_rast_ready = 1; rand_vtx();
      step();
    end
    chk("pushpop_count", 128'(dut.count), 128'(DEPTH));
    chk("pushpop_no_ovf", 128'(bus.o_overflow), 128'(0));
    bus.i_rast_ready = 0; bus.i_tri_dv = 1; rand_vtx();
    step();
    chk("ovf_set", 128'(bus.o_overflow), 128'(1));
    chk("ovf_count", 128'(dut.count), 128'(DEPTH));
    idle_in();
    sent_in_model = 0;
    stream_loop(1, 2000);

    // Mid-stream: a second start is ignored, then reset aborts with four triangles queued.
    bus.i_start = 1; bus.i_num_models = NW'(2);
    step();
    bus.i_start = 0; bus.i_tp_ready = 1;
    step();
    bus.i_tp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      bus.i_tri_dv = 1; bus.i_tri_last = 0; rand_vtx();
      step();
    end
    idle_in();
    bus.i_start = 1; bus.i_num_models = NW'(5);
    step();
    bus.i_start = 0;
    chk("start_ignored_ready", 128'(bus.o_ready), 128'(0));
    chk("queued4", 128'(dut.count), 128'(4));
    rstn = 0;
    step();
    rstn = 1;
    chk("abort_ready", 128'(bus.o_ready), 128'(1));
    chk("abort_tri_dv", 128'(bus.o_tri_dv), 128'(0));
    chk("abort_count", 128'(dut.count), 128'(0));
    chk("abort_finished", 128'(bus.o_finished), 128'(0));
    chk("abort_overflow", 128'(bus.o_overflow), 128'(0));

    // A few random frames after the abort.
    for (int f = 0; f < 4; f++) run_frame($urandom_range(1, 4), $urandom_range(1, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
